act_port_sched: RTL and testbench
=================================

# act_port_sched

Burst scheduler that sits in front of `act_port` and owns its ping-pong banks. It accepts activation write requests of arbitrary length and splits them into `act_port` bursts. No burst exceeds `MAX_BURST` beats or crosses a bank boundary. It also tracks the fill level of the Ping (bank 0/1) and Pong (bank 2/3) halves, raises a full flag per half, and stalls until the downstream consumer releases a half before writing into it again.

## Interface
Parameters:
- `BANK_WORDS`, 2048: 256-bit beats per ping-pong half. Must match the `act_port` address wrap point (32752/16 + 1).
- `MAX_BURST`, 256: maximum beats per `act_port` burst.
- `LEN_W`, 13: width of length fields; matches the `act_port` `tran_time` width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: upstream request valid.
- `req_len` in `LEN_W`: beats requested.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `act_port_start` out 1: one-cycle start pulse to `act_port`.
- `tran_time` out `LEN_W`: burst length. Held stable from `act_port_start` until `done`.
- `done` in 1: burst-complete pulse from `act_port`.
- `burst_active` out 1: high from the `act_port_start` cycle through the `done` cycle.
- `cur_bank` out 1: 0 = Ping, 1 = Pong. Mirrors the `act_port` pingpang bit.
- `bank_full` out 2: bit i set when half i holds `BANK_WORDS` beats.
- `bank_release` in 2: consumer pulse. Bit i frees half i.
- `err_len` out 1: one-cycle pulse when a request with `req_len == 0` is accepted.
- `err_timeout` out 1: sticky watchdog error (see Configuration).

## Operation
- FSM states: IDLE, WAIT_BANK, START, WAIT_DONE, UPDATE.
- IDLE:
  - `req_ready` = 1 in this state only.
  - On accept with `req_len == 0`: pulse `err_len`, stay in IDLE.
  - On accept with `req_len != 0`: latch `remain <= req_len`, go to WAIT_BANK.
- WAIT_BANK:
  - If `bank_full[cur_bank]` is 1, hold in WAIT_BANK.
  - Otherwise compute `chunk = min(remain, BANK_WORDS - fill, MAX_BURST)`, register it into `tran_time`, go to START.
- START: drive `act_port_start` = 1 for exactly one cycle, go to WAIT_DONE.
- WAIT_DONE: wait for `done`, go to UPDATE. A `done` seen in any other state is ignored.
- UPDATE:
  - `fill += chunk`; `remain -= chunk`.
  - If `fill` reaches `BANK_WORDS`: set `bank_full[cur_bank]`, toggle `cur_bank`, clear `fill` to 0.
  - If `remain == 0`, go to IDLE; otherwise go to WAIT_BANK.
- Arithmetic:
  - `fill` is `$clog2(BANK_WORDS)+1` bits.
  - The min is unsigned.
  - The `BANK_WORDS - fill` term is never 0 while in WAIT_BANK, because a half is swapped as soon as it fills.
- `bank_release[i]` clears `bank_full[i]`. Release of a half that is not full is ignored.
- If set and release of the same half occur in the same cycle, set wins.
- Reset values:
  - State IDLE; `fill`, `remain` = 0.
  - `cur_bank` = 0, `bank_full` = 2'b00, `tran_time` = 0.
  - All pulse outputs = 0; `err_timeout` = 0.
- Reset mid-burst returns to IDLE. `act_port` must be reset in the same cycle, because its global address is not resynchronised.

## Timing
- Accept to `act_port_start`: 2 cycles when the target half is free (WAIT_BANK, then START).
- `done` to the next `act_port_start` of the same request: 3 cycles (UPDATE, WAIT_BANK, START).
- `done` to `req_ready` high: 2 cycles (UPDATE, then IDLE).
- `bank_full` and `cur_bank` update in the cycle after UPDATE, which is before the next start.
- `bank_release` takes effect on the following edge. A scheduler stalled in WAIT_BANK issues start 2 cycles after the release.

## Configuration
- `ACT_PORT_SCHED_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles spent in WAIT_DONE.
  - At 65535 it sets `err_timeout` (sticky until `rst`), drops the outstanding request, and returns to IDLE. `fill`, `cur_bank` and `bank_full` are unchanged.
- Not defined: `err_timeout` is tied to 0, no counter is instantiated, and WAIT_DONE waits indefinitely.

## Structure
- Shared package `act_pkg` holds:
  - the FSM state enum;
  - `ACT_LEN_W`, `ACT_BANK_WORDS` and `ACT_MAX_BURST` constants, also consumed by `act_port` integration;
  - `ACT_WDT_W` = 16.
- Sub-module `act_chunk_calc`: combinational three-way unsigned min, registered by the parent. Everything else stays flat.

## Test plan
- Single burst: `req_len` = 100 → one start with `tran_time` = 100; after `done`, `fill` = 100, `cur_bank` = 0, `req_ready` high 2 cycles later.
- Length split: `req_len` = 600 → starts with `tran_time` 256, 256, 88 in order, each issued 3 cycles after the previous `done`.
- Bank boundary: preload `fill` = 2000 via a 2000-beat request, then `req_len` = 100 → bursts of 48 then 52; `bank_full` = 2'b01 and `cur_bank` = 1 between them.
- Back-pressure: fill both halves (4096 beats), then request 10 → scheduler holds in WAIT_BANK with no start; pulse `bank_release` = 2'b01 → start with `tran_time` = 10 two cycles later.
- Zero length and collision: `req_len` = 0 → `err_len` pulse, no start. Release of half 1 in the same cycle its set occurs → `bank_full[1]` stays 1.
- Watchdog (macro defined): withhold `done` for 65535 cycles → `err_timeout` = 1 and the FSM is in IDLE. With the macro undefined, `err_timeout` stays 0.

Source files
------------

// File: rtl/act_pkg.sv
// Shared constants and scheduler state encoding for the act_port burst path.
package act_pkg;

  localparam int ACT_LEN_W      = 13;
  localparam int ACT_BANK_WORDS = 2048;
  localparam int ACT_MAX_BURST  = 256;
  localparam int ACT_WDT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BANK,
    START,
    WAIT_DONE,
    UPDATE
  } sched_state_t;

endpackage

// File: rtl/act_port_sched_if.sv
// Request and act_port burst handshake bundle; slave is the scheduler side.
interface act_port_sched_if #(
  parameter int LEN_W = 13
);
  logic             req_valid;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             act_port_start;
  logic [LEN_W-1:0] tran_time;
  logic             done;
  logic             burst_active;

  modport master (
    output req_valid, req_len, done,
    input  req_ready, act_port_start, tran_time, burst_active
  );

  modport slave (
    input  req_valid, req_len, done,
    output req_ready, act_port_start, tran_time, burst_active
  );
endinterface

// File: rtl/act_chunk_calc.sv
// Burst length selection: unsigned min of remaining beats, space left in the
// current half and the per-burst cap.
module act_chunk_calc
  import act_pkg::*;
#(
  parameter int LEN_W      = ACT_LEN_W,
  parameter int BANK_WORDS = ACT_BANK_WORDS,
  parameter int MAX_BURST  = ACT_MAX_BURST,
  parameter int FILL_W     = $clog2(BANK_WORDS) + 1
) (
  input  logic [LEN_W-1:0]  remain,
  input  logic [FILL_W-1:0] fill,
  output logic [LEN_W-1:0]  chunk
);

  logic [LEN_W-1:0] space;
  logic [LEN_W-1:0] cap;

  always_comb begin
    space = LEN_W'(FILL_W'(BANK_WORDS) - fill);
    cap   = LEN_W'(MAX_BURST);
    chunk = remain;
    if (space < chunk) chunk = space;
    if (cap < chunk)   chunk = cap;
  end

endmodule

// File: rtl/act_port_sched.sv
// Burst scheduler in front of act_port: splits requests, tracks ping-pong fill.
// Optional WAIT_DONE watchdog enabled by ACT_PORT_SCHED_TIMEOUT_EN.
module act_port_sched
  import act_pkg::*;
#(
  parameter int BANK_WORDS = ACT_BANK_WORDS,
  parameter int MAX_BURST  = ACT_MAX_BURST,
  parameter int LEN_W      = ACT_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  act_port_sched_if.slave         bus,
  output logic                    cur_bank,
  output logic [1:0]              bank_full,
  input  logic [1:0]              bank_release,
  output logic                    err_len,
  output logic                    err_timeout
);

  localparam int FILL_W = $clog2(BANK_WORDS) + 1;

  sched_state_t      state, state_nxt;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_sum;
  logic [LEN_W-1:0]  remain;
  logic [LEN_W-1:0]  chunk;
  logic [LEN_W-1:0]  tran_time;
  logic [1:0]        bank_set;
  logic              accept;
  logic              wrap;
  logic              bank_free;
  logic              timeout;

  act_chunk_calc #(
    .LEN_W      (LEN_W),
    .BANK_WORDS (BANK_WORDS),
    .MAX_BURST  (MAX_BURST),
    .FILL_W     (FILL_W)
  ) u_chunk (
    .remain (remain),
    .fill   (fill),
    .chunk  (chunk)
  );

  assign bus.tran_time = tran_time;
  assign accept        = (state == IDLE) && bus.req_valid;
  assign bank_free     = !bank_full[cur_bank];
  assign fill_sum      = fill + FILL_W'(tran_time);
  assign wrap          = (fill_sum == FILL_W'(BANK_WORDS));
  // Set and release on the same edge: set is OR-ed in after the clear.
  assign bank_set      = (state == UPDATE && wrap) ? (2'b01 << cur_bank) : 2'b00;

`ifdef ACT_PORT_SCHED_TIMEOUT_EN
  logic [ACT_WDT_W-1:0] wdt;

  assign timeout = (state == WAIT_DONE) && !bus.done && (wdt == '1);

  always_ff @(posedge clk) begin
    if (rst || state != WAIT_DONE) wdt <= '0;
    else                           wdt <= wdt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)          err_timeout <= 1'b0;
    else if (timeout) err_timeout <= 1'b1;
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    bus.req_ready      = 1'b0;
    bus.act_port_start = 1'b0;
    bus.burst_active   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid && bus.req_len != '0) state_nxt = WAIT_BANK;
      end
      WAIT_BANK: if (bank_free) state_nxt = START;
      START: begin
        bus.act_port_start = 1'b1;
        bus.burst_active   = 1'b1;
        state_nxt          = WAIT_DONE;
      end
      WAIT_DONE: begin
        bus.burst_active = 1'b1;
        if (bus.done)     state_nxt = UPDATE;
        else if (timeout) state_nxt = IDLE;
      end
      UPDATE:  state_nxt = (remain == tran_time) ? IDLE : WAIT_BANK;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill      <= '0;
      remain    <= '0;
      tran_time <= '0;
      cur_bank  <= 1'b0;
      bank_full <= 2'b00;
      err_len   <= 1'b0;
    end else begin
      err_len   <= accept && (bus.req_len == '0);
      bank_full <= (bank_full & ~bank_release) | bank_set;
      if (accept && bus.req_len != '0) remain <= bus.req_len;
      if (state == WAIT_BANK && bank_free) tran_time <= chunk;
      if (state == UPDATE) begin
        remain <= remain - tran_time;
        if (wrap) begin
          fill     <= '0;
          cur_bank <= ~cur_bank;
        end else begin
          fill <= fill_sum;
        end
      end
      if (timeout) remain <= '0;
    end
  end

endmodule

// File: tb/tb_act_port_sched.sv
// Directed bench for act_port_sched: split, bank wrap, back-pressure, errors.
module tb_act_port_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cur_bank;
  logic [1:0] bank_full;
  logic [1:0] bank_release;
  logic       err_len;
  logic       err_timeout;
  int         checks = 0;
  int         errors = 0;

  act_port_sched_if #(.LEN_W(13)) bus ();

  act_port_sched #(
    .BANK_WORDS (2048),
    .MAX_BURST  (256),
    .LEN_W      (13)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cur_bank     (cur_bank),
    .bank_full    (bank_full),
    .bank_release (bank_release),
    .err_len      (err_len),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic accept(input int len);
    check("accept_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_len   = 13'(len);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int exp_lat, input int exp_tt);
    int n = 0;
    while (!bus.act_port_start && n < 50) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_tt"}, 32'(bus.tran_time), 32'(exp_tt));
  endtask

  // Leaves the bench in the UPDATE cycle with rel driven on bank_release.
  task automatic give_done(input logic [1:0] rel);
    step();
    bus.done = 1'b1;
    step();
    bus.done     = 1'b0;
    bank_release = rel;
  endtask

  task automatic run_req(input string tag, input int len, input int n_max,
                         input int last, input logic [1:0] rel_last);
    int total = n_max + ((last != 0) ? 1 : 0);
    accept(len);
    for (int k = 0; k < total; k++) begin
      wait_start(tag, (k == 0) ? 1 : 2, (k < n_max) ? 256 : last);
      give_done((k == total - 1) ? rel_last : 2'b00);
    end
    step();
    bank_release = 2'b00;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int starts;
    bus.req_valid = 1'b0;
    bus.req_len   = '0;
    bus.done      = 1'b0;
    bank_release  = 2'b00;
    rst           = 1'b1;
    step();
    step();
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_start", 32'(bus.act_port_start), 32'd0);
    check("rst_active", 32'(bus.burst_active), 32'd0);
    check("rst_tt", 32'(bus.tran_time), 32'd0);
    check("rst_bank", 32'(cur_bank), 32'd0);
    check("rst_full", 32'(bank_full), 32'd0);
    check("rst_errlen", 32'(err_len), 32'd0);
    check("rst_errto", 32'(err_timeout), 32'd0);
    rst = 1'b0;

    // Single burst of 100
    accept(100);
    wait_start("single", 1, 100);
    check("single_active", 32'(bus.burst_active), 32'd1);
    step();
    check("single_pulse", 32'(bus.act_port_start), 32'd0);
    check("single_wait_active", 32'(bus.burst_active), 32'd1);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check("single_upd_ready", 32'(bus.req_ready), 32'd0);
    step();
    check("single_ready", 32'(bus.req_ready), 32'd1);
    check("single_fill", 32'(dut.fill), 32'd100);
    check("single_bank", 32'(cur_bank), 32'd0);

    // Length split 600 -> 256, 256, 88
    accept(600);
    wait_start("split0", 1, 256);
    give_done(2'b00);
    wait_start("split1", 2, 256);
    give_done(2'b00);
    wait_start("split2", 2, 88);
    give_done(2'b00);
    step();
    check("split_ready", 32'(bus.req_ready), 32'd1);
    check("split_fill", 32'(dut.fill), 32'd700);

    // Bank boundary: preload 2000, then 100 -> 48 + 52
    do_reset();
    run_req("pre2000", 2000, 7, 208, 2'b00);
    check("pre_fill", 32'(dut.fill), 32'd2000);
    accept(100);
    wait_start("bnd0", 1, 48);
    give_done(2'b00);
    step();
    check("bnd_full", 32'(bank_full), 32'b01);
    check("bnd_bank", 32'(cur_bank), 32'd1);
    wait_start("bnd1", 1, 52);
    give_done(2'b00);
    step();
    check("bnd_ready", 32'(bus.req_ready), 32'd1);
    check("bnd_fill", 32'(dut.fill), 32'd52);

    // Fill both halves; release half 1 on the edge that sets it
    do_reset();
    run_req("fill4k", 4096, 16, 0, 2'b10);
    check("collide_full", 32'(bank_full), 32'b11);
    check("collide_bank", 32'(cur_bank), 32'd0);

    // Back-pressure until half 0 is released
    accept(10);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      starts += int'(bus.act_port_start);
      step();
    end
    check("stall_starts", 32'(starts), 32'd0);
    check("stall_ready", 32'(bus.req_ready), 32'd0);
    bank_release = 2'b01;
    step();
    bank_release = 2'b00;
    wait_start("release", 1, 10);
    give_done(2'b00);
    step();
    check("release_ready", 32'(bus.req_ready), 32'd1);
    check("release_full", 32'(bank_full), 32'b10);

    // Zero length request and stray done in IDLE
    bus.req_valid = 1'b1;
    bus.req_len   = '0;
    step();
    bus.req_valid = 1'b0;
    check("zero_errlen", 32'(err_len), 32'd1);
    check("zero_ready", 32'(bus.req_ready), 32'd1);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check("zero_errlen_clr", 32'(err_len), 32'd0);
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      starts += int'(bus.act_port_start);
      step();
    end
    check("zero_starts", 32'(starts), 32'd0);
    check("zero_idle", 32'(bus.req_ready), 32'd1);

    // Watchdog
    accept(5);
    wait_start("wdt", 1, 5);
`ifdef ACT_PORT_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      while (!err_timeout && n < 66000) begin
        step();
        n++;
      end
    end
    check("wdt_err", 32'(err_timeout), 32'd1);
    check("wdt_idle", 32'(bus.req_ready), 32'd1);
    check("wdt_full", 32'(bank_full), 32'b10);
    check("wdt_bank", 32'(cur_bank), 32'd0);
`else
    for (int i = 0; i < 1000; i++) step();
    check("wdt_err", 32'(err_timeout), 32'd0);
    check("wdt_active", 32'(bus.burst_active), 32'd1);
    give_done(2'b00);
    step();
    check("wdt_ready", 32'(bus.req_ready), 32'd1);
    check("wdt_fill", 32'(dut.fill), 32'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
